// File: rtl/frac_clk_ctrl.sv
// Sequencer for a fractional clock-enable generator: validates ratio requests, reloads the
// generator's factors under generator reset, then gates and counts enables. Option: FRAC_CLK_CTRL_TICK_COUNT_EN.
module frac_clk_ctrl #(
  parameter int COUNTER_BITS = 8,
  parameter int TICK_BITS    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic signed [COUNTER_BITS-1:0] req_mul,
  input  logic signed [COUNTER_BITS-1:0] req_div,
  input  logic        [TICK_BITS-1:0]    req_ticks,
  input  logic                           stop,
  output logic                           gen_reset,
  output logic signed [COUNTER_BITS-1:0] gen_factor_mul,
  output logic signed [COUNTER_BITS-1:0] gen_factor_div,
  input  logic                           gen_en,
  output logic                           en_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic        [TICK_BITS-1:0]    tick_count
);
  typedef enum logic [2:0] {IDLE, CHECK, FLUSH, RUN, DONE} state_t;

  localparam logic signed [COUNTER_BITS-1:0] ZERO    = '0;
  localparam logic signed [COUNTER_BITS-1:0] DIV_MAX = COUNTER_BITS'((1 << (COUNTER_BITS-2)) - 1);

  state_t                         state, state_nx;
  logic signed [COUNTER_BITS-1:0] p_mul, p_div;
  logic                           from_run, flush_2nd;
  logic                           accept, req_ok, run_en, term;

  assign accept = req_valid && req_ready;
  assign req_ok = (p_mul > ZERO) && (p_mul < p_div) && (p_div <= DIV_MAX);
  assign run_en = (state == RUN) && gen_en;
  assign en_out = run_en;
  assign busy   = (state != IDLE);

`ifdef FRAC_CLK_CTRL_TICK_COUNT_EN
  localparam logic [TICK_BITS-1:0] ONE = TICK_BITS'(1);
  logic [TICK_BITS-1:0] p_ticks, ticks_q, tick_q;

  // run length only becomes active once the request passes validation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_ticks <= '0;
      ticks_q <= '0;
      tick_q  <= '0;
    end else begin
      if (accept) p_ticks <= req_ticks;
      if (state == CHECK && req_ok) begin
        ticks_q <= p_ticks;
        tick_q  <= '0;
      end else if (run_en) begin
        tick_q <= tick_q + ONE;
      end
    end
  end

  assign term       = (ticks_q != '0) && run_en && (tick_q == ticks_q - ONE);
  assign tick_count = tick_q;
`else
  logic unused_ticks;
  assign unused_ticks = ^req_ticks;
  assign term         = 1'b0;
  assign tick_count   = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      p_mul          <= '0;
      p_div          <= '0;
      from_run       <= 1'b0;
      flush_2nd      <= 1'b0;
      gen_factor_mul <= '0;
      gen_factor_div <= '0;
    end else begin
      state     <= state_nx;
      flush_2nd <= (state == FLUSH) && !flush_2nd;
      if (accept) begin
        p_mul    <= req_mul;
        p_div    <= req_div;
        from_run <= (state == RUN);
      end
      if (state == CHECK && req_ok) begin
        gen_factor_mul <= p_mul;
        gen_factor_div <= p_div;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    gen_reset = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = CHECK;
      end
      CHECK: begin
        // a rejected retune must leave the running generator untouched
        gen_reset = !from_run;
        if (req_ok) begin
          state_nx = FLUSH;
        end else begin
          err      = 1'b1;
          state_nx = from_run ? RUN : IDLE;
        end
      end
      FLUSH: begin
        if (flush_2nd) state_nx = RUN;
      end
      RUN: begin
        gen_reset = 1'b0;
        req_ready = !stop && !term;
        if (stop || term)   state_nx = DONE;
        else if (req_valid) state_nx = CHECK;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
